rf_wb_queue: RTL
================

Name: rf_wb_queue

Overview:
- Write-side initiator for the 8-entry register file: queues writeback requests from the datapath and drives the RF write port (data, write address, write enable) one entry per cycle.
- Sits between execute/writeback stages and the register file.
- Also forwards pending (queued, not yet written) data onto the two read paths, so readers never see stale RF contents.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDR_WIDTH, 3, register address width (8 registers).
- DEPTH, 4, queue entries; power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH), pointer width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_valid_i  in  1  writeback request valid.
- wr_ready_o  out  1  queue can accept a request this cycle.
- wr_addr_i  in  ADDR_WIDTH  destination register.
- wr_data_i  in  DATA_WIDTH  writeback data.
- drain_en_i  in  1  RF write port available this cycle.
- rf_we_o  out  1  RF write enable.
- rf_addr_o  out  ADDR_WIDTH  RF write address.
- rf_data_o  out  DATA_WIDTH  RF write data.
- rd_addr_a_i  in  ADDR_WIDTH  read port A address (same value the RF sees).
- rd_addr_b_i  in  ADDR_WIDTH  read port B address.
- rf_rda_i  in  DATA_WIDTH  RF read data A.
- rf_rdb_i  in  DATA_WIDTH  RF read data B.
- rda_o  out  DATA_WIDTH  forwarded read data A.
- rdb_o  out  DATA_WIDTH  forwarded read data B.
- count_o  out  PTR_W+1  entries held, 0..DEPTH.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries {addr, data, valid}.
  - head pointer = oldest entry; tail pointer = next free slot; count register.
  - Pointers wrap modulo DEPTH.
- Reset (rst=1 at clock edge):
  - head = tail = 0, count = 0, all valid bits cleared.
  - Outputs after reset: count_o=0, empty_o=1, full_o=0, wr_ready_o=1, rf_we_o=0.
  - Reset mid-operation discards all pending writes; none reach the RF.
  - Reset has priority over push and pop in the same cycle.
- wr_ready_o = !full_o. Combinational from registered count; no dependence on drain_en_i.
- push = wr_valid_i & wr_ready_o.
  - Writes {wr_addr_i, wr_data_i, valid=1} at tail; tail+1.
  - wr_valid_i while full is ignored; the source must hold the request until ready.
- RF drive (combinational from head):
  - rf_addr_o / rf_data_o = head entry.
  - rf_we_o = !empty_o & drain_en_i.
  - When empty, rf_addr_o = 0 and rf_data_o = 0.
- pop = rf_we_o.
  - Clears head valid; head+1. The RF commits the write on the same edge.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged (legal when full: no push, since ready=0; legal when empty: no pop).
- Latency: a request pushed at edge N is earliest written to the RF at edge N+1, given drain_en_i=1 in cycle N+1.
- Ordering: strict FIFO. Multiple queued writes to the same register commit in arrival order; no coalescing.
- Forwarding (combinational), per port independently:
  - Scan valid entries from youngest (tail-1) to oldest (head).
  - First entry whose addr matches rd_addr_x_i supplies rdx_o; otherwise rdx_o = rf_rdx_i.
  - The entry being popped this cycle still forwards (the RF is not yet updated).
  - A request being pushed this cycle does not forward.
- Entries never written since reset are not valid and never match.

Test Plan:
- Reset then idle -> count_o=0, empty_o=1, wr_ready_o=1, rf_we_o=0, rda_o=rf_rda_i.
- Push (addr 3, 0xDEADBEEF) with drain_en_i=0 for 3 cycles, then drain_en_i=1 -> rf_we_o=1, rf_addr_o=3, rf_data_o=0xDEADBEEF for one cycle; count_o 1->0.
- Push 4 entries (addr 1..4, data 0x11..0x44) with drain_en_i=0 -> full_o=1, wr_ready_o=0; a 5th request (addr 5) is not accepted. Enable drain -> RF writes 1,2,3,4 in order on consecutive cycles; after head wraps, a push lands in slot 0.
- Queue addr 2 with 0xA, then addr 2 with 0xB, undrained; rd_addr_a_i=2 and rf_rda_i=0x0 -> rda_o=0xB. rd_addr_b_i=6 -> rdb_o=rf_rdb_i.
- Steady state with count=2, push and pop in the same cycle -> count_o stays 2; order is preserved across 10 consecutive cycles.
- Queue 3 entries, assert rst for 1 cycle, then drain_en_i=1 -> no rf_we_o pulse; count_o=0; forwarding disabled (rda_o=rf_rda_i).

Source files
------------

// File: rtl/rf_wb_queue.sv
// Writeback queue in front of the register file write port.
// Buffers writes in order and forwards pending data to both read ports.
module rf_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  drain_en_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
  input  logic [DATA_WIDTH-1:0] rf_rda_i,
  input  logic [DATA_WIDTH-1:0] rf_rdb_i,
  output logic [DATA_WIDTH-1:0] rda_o,
  output logic [DATA_WIDTH-1:0] rdb_o,
  output logic [PTR_W:0]        count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [PTR_W:0]        count_q;
  logic                  push;
  logic                  pop;
  logic [PTR_W-1:0]      idx;

  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign wr_ready_o = !full_o;
  assign push       = wr_valid_i && wr_ready_o;
  assign rf_we_o    = !empty_o && drain_en_i;
  assign pop        = rf_we_o;
  assign rf_addr_o  = empty_o ? '0 : addr_q[head_q];
  assign rf_data_o  = empty_o ? '0 : data_q[head_q];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wr_addr_i;
      data_q[tail_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      unique case (1'b1)
        push && !pop: count_q <= count_q + 1'b1;
        pop && !push: count_q <= count_q - 1'b1;
        default:      ;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    rda_o = rf_rda_i;
    rdb_o = rf_rdb_i;
    idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && addr_q[idx] == rd_addr_a_i)
        rda_o = data_q[idx];
      if (vld_q[idx] && addr_q[idx] == rd_addr_b_i)
        rdb_o = data_q[idx];
    end
  end

endmodule
